// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: valid/ready command front end for the 16-bit combinational ALU breadboard.
// Define ALU_ILLEGAL_OP_CHECK_EN to answer opcodes outside 0100..1000 with an error instead of issuing them.
module alu_cmd_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [15:0]      cmd_a,
    input  logic [15:0]      cmd_b,
    input  logic             cmd_use_acc,
    output logic [3:0]       alu_opcode,
    output logic [15:0]      alu_a,
    output logic [15:0]      alu_b,
    input  logic [32:0]      alu_c,
    input  logic [1:0]       alu_error,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [32:0]      rsp_c,
    output logic [1:0]       rsp_error,
    output logic [32:0]      acc,
    output logic [CNT_W-1:0] ovf_cnt,
    output logic [CNT_W-1:0] dz_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic        w_accept;
    logic        w_capture;
    logic        w_op_legal;
    logic [15:0] w_b_sel;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}})) begin
            return v + CNT_W'(1);
        end
        return v;
    endfunction

`ifdef ALU_ILLEGAL_OP_CHECK_EN
    assign w_op_legal = (cmd_op >= 4'b0100) && (cmd_op <= 4'b1000);
`else
    assign w_op_legal = 1'b1;
`endif

    // Feedback operand: only the low half of the accumulator is meaningful to a 16-bit ALU.
    assign w_b_sel = cmd_use_acc ? acc[15:0] : cmd_b;

    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Held low while reset is asserted so no command is offered during reset.
                cmd_ready = rst;
                if (cmd_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_op_legal ? ST_HOLD : ST_RESP;
                end
            end
            ST_HOLD: begin
                if (r_cnt == 4'd0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt      <= 4'd0;
            alu_opcode <= 4'd0;
            alu_a      <= 16'd0;
            alu_b      <= 16'd0;
            rsp_c      <= 33'd0;
            rsp_error  <= 2'd0;
            acc        <= 33'd0;
            ovf_cnt    <= '0;
            dz_cnt     <= '0;
        end else begin
            if (w_accept && w_op_legal) begin
                alu_opcode <= cmd_op;
                alu_a      <= cmd_a;
                alu_b      <= w_b_sel;
                r_cnt      <= SETTLE_LOAD;
            end
            if ((r_state == ST_HOLD) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_capture) begin
                rsp_c     <= alu_c;
                rsp_error <= alu_error;
                acc       <= alu_c;
                ovf_cnt   <= sat_inc(ovf_cnt, alu_error[0]);
                dz_cnt    <= sat_inc(dz_cnt, alu_error[1]);
            end
`ifdef ALU_ILLEGAL_OP_CHECK_EN
            // Rejected opcode: answer immediately, ALU inputs, acc and counters untouched.
            if (w_accept && !w_op_legal) begin
                rsp_c     <= 33'd0;
                rsp_error <= 2'b11;
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer wired to a behavioural model of the 16-bit ALU breadboard.
// Honours ALU_ILLEGAL_OP_CHECK_EN in its expectations the same way the design does.
module tb_alu_cmd_sequencer;

    localparam int SETTLE = 2;
    localparam int CNT_W  = 8;
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [15:0]      cmd_a;
    logic [15:0]      cmd_b;
    logic             cmd_use_acc;
    logic [3:0]       alu_opcode;
    logic [15:0]      alu_a;
    logic [15:0]      alu_b;
    logic [32:0]      alu_c;
    logic [1:0]       alu_error;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [32:0]      rsp_c;
    logic [1:0]       rsp_error;
    logic [32:0]      acc;
    logic [CNT_W-1:0] ovf_cnt;
    logic [CNT_W-1:0] dz_cnt;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference state of the sequencer
    logic [32:0]      m_acc;
    logic [CNT_W-1:0] m_ovf;
    logic [CNT_W-1:0] m_dz;
    logic [3:0]       m_op;
    logic [15:0]      m_a;
    logic [15:0]      m_b;

    alu_cmd_sequencer #(.SETTLE_CYCLES(SETTLE), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_c(alu_c), .alu_error(alu_error),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_c(rsp_c), .rsp_error(rsp_error),
        .acc(acc), .ovf_cnt(ovf_cnt), .dz_cnt(dz_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU breadboard: C = B op A; error[0] result beyond 16 bits / borrow, error[1] divide by zero.
    function automatic logic [34:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [32:0] c;
        logic [1:0]  e;
        c = '0;
        e = '0;
        case (op)
            4'b0100: begin c = 33'(b) + 33'(a); e[0] = (c > 33'h0FFFF); end
            4'b0101: begin c = 33'(b) - 33'(a); e[0] = (b < a); end
            4'b0110: begin c = 33'(b) * 33'(a); e[0] = (c > 33'h0FFFF); end
            4'b0111: if (a == 16'd0) e[1] = 1'b1; else c = 33'(b / a);
            4'b1000: if (a == 16'd0) e[1] = 1'b1; else c = 33'(b % a);
            default: c = {17'd0, a ^ b};
        endcase
        return {e, c};
    endfunction

    always_comb {alu_error, alu_c} = alu_fn(alu_opcode, alu_a, alu_b);

    task automatic model_reset();
        m_acc = '0; m_ovf = '0; m_dz = '0; m_op = '0; m_a = '0; m_b = '0;
    endtask

    task automatic model_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                             input logic ua, output logic [32:0] xc, output logic [1:0] xe, output int xlat);
        logic [15:0] bsel;
        logic [34:0] r;
        bit          illegal;
        bsel    = ua ? m_acc[15:0] : b;
        illegal = 1'b0;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
        illegal = (op < 4'd4) || (op > 4'd8);
`endif
        if (illegal) begin
            xc = '0; xe = 2'b11; xlat = 0;
        end else begin
            r = alu_fn(op, a, bsel);
            xc = r[32:0]; xe = r[34:33]; xlat = SETTLE;
            m_acc = xc;
            if (xe[0] && m_ovf < CMAX) m_ovf = m_ovf + 1'b1;
            if (xe[1] && m_dz < CMAX) m_dz = m_dz + 1'b1;
            m_op = op; m_a = a; m_b = bsel;
        end
    endtask

    // Runs one full transaction from posedge+1 and reports what was observed.
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic ua,
                         input int hold, output int lat, output logic [32:0] c, output logic [1:0] e,
                         output logic [32:0] acc_s, output logic [35:0] alu_s, output bit stable,
                         output bit idle_ok, output int t_acc);
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 50) begin @(posedge clk); #1; guard++; end
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua;
        rsp_ready = (hold == 0);
        @(posedge clk); #1;
        t_acc = cyc;
        cmd_valid = 1'b0; cmd_op = 4'($urandom); cmd_a = 16'($urandom);
        cmd_b = 16'($urandom); cmd_use_acc = 1'($urandom);
        alu_s = {alu_opcode, alu_a, alu_b};
        lat = 0;
        while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        c = rsp_c; e = rsp_error; acc_s = acc;
        stable = 1'b1;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            if (!rsp_valid || rsp_c !== c || rsp_error !== e || cmd_ready) stable = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        idle_ok = !rsp_valid && cmd_ready;
        rsp_ready = 1'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_use_acc = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({alu_opcode, alu_a, alu_b, rsp_valid, rsp_c, rsp_error, acc, ovf_cnt, dz_cnt, cmd_ready} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got rsp_valid=%0b cmd_ready=%0b acc=%0h alu_op=%0h required all zero",
                              rsp_valid, cmd_ready, acc, alu_opcode);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %0b required 1", cmd_ready); end
        model_reset();
    endtask

    task automatic test_add();
        logic [32:0] xc, c, as; logic [1:0] xe, e; logic [35:0] al; int xl, lat, t; bit st, io;
        model_cmd(4'b0100, 16'd12, 16'd10, 1'b0, xc, xe, xl);
        issue(4'b0100, 16'd12, 16'd10, 1'b0, 0, lat, c, e, as, al, st, io, t);
        n_vec++; if (lat != 2) begin n_err++; $display("FAIL add_latency: got %0d required 2", lat); end
        n_vec++; if (c !== 33'd22) begin n_err++; $display("FAIL add_c: got %0d required 22", c); end
        n_vec++; if (e !== 2'b00) begin n_err++; $display("FAIL add_err: got %0b required 00", e); end
        n_vec++; if (as !== 33'd22) begin n_err++; $display("FAIL add_acc: got %0d required 22", as); end
        n_vec++; if (al !== {4'b0100, 16'd12, 16'd10}) begin n_err++; $display("FAIL add_alu_in: got %0h required %0h", al, {4'b0100, 16'd12, 16'd10}); end
        n_vec++; if (io !== 1'b1) begin n_err++; $display("FAIL add_return_idle: got %0b required 1", io); end
    endtask

    task automatic test_chain();
        logic [32:0] xc, c, as; logic [1:0] xe, e; logic [35:0] al; int xl, lat, t; bit st, io;
        model_cmd(4'b0110, 16'd20, 16'd20, 1'b0, xc, xe, xl);
        issue(4'b0110, 16'd20, 16'd20, 1'b0, 0, lat, c, e, as, al, st, io, t);
        n_vec++; if (c !== 33'd400) begin n_err++; $display("FAIL chain_mul_c: got %0d required 400", c); end
        model_cmd(4'b0101, 16'd400, 16'd7, 1'b1, xc, xe, xl);
        issue(4'b0101, 16'd400, 16'd7, 1'b1, 0, lat, c, e, as, al, st, io, t);
        n_vec++; if (al[15:0] !== 16'd400) begin n_err++; $display("FAIL chain_b_from_acc: got %0d required 400", al[15:0]); end
        n_vec++; if (c !== 33'd0 || e !== 2'b00) begin n_err++; $display("FAIL chain_sub: got c=%0d err=%0b required 0/00", c, e); end
    endtask

    task automatic test_div_mod();
        logic [32:0] xc, c, as; logic [1:0] xe, e; logic [35:0] al; int xl, lat, t; bit st, io;
        model_cmd(4'b0111, 16'd0, 16'd20, 1'b0, xc, xe, xl);
        issue(4'b0111, 16'd0, 16'd20, 1'b0, 0, lat, c, e, as, al, st, io, t);
        n_vec++; if (e !== 2'b10) begin n_err++; $display("FAIL div0_err: got %0b required 10", e); end
        n_vec++; if (dz_cnt !== 8'd1) begin n_err++; $display("FAIL div0_cnt: got %0d required 1", dz_cnt); end
        n_vec++; if (ovf_cnt !== 8'd0) begin n_err++; $display("FAIL div0_ovf_cnt: got %0d required 0", ovf_cnt); end
        model_cmd(4'b1000, 16'd2, 16'd11, 1'b0, xc, xe, xl);
        issue(4'b1000, 16'd2, 16'd11, 1'b0, 0, lat, c, e, as, al, st, io, t);
        n_vec++; if (c !== 33'd1 || e !== 2'b00) begin n_err++; $display("FAIL mod: got c=%0d err=%0b required 1/00", c, e); end
    endtask

    task automatic test_backpressure();
        logic [32:0] xc, c, as; logic [1:0] xe, e; logic [35:0] al; int xl, lat, t; bit st, io;
        model_cmd(4'b0100, 16'hFFFF, 16'h0003, 1'b0, xc, xe, xl);
        issue(4'b0100, 16'hFFFF, 16'h0003, 1'b0, 5, lat, c, e, as, al, st, io, t);
        n_vec++; if (c !== xc || e !== xe) begin n_err++; $display("FAIL bp_result: got %0h/%0b required %0h/%0b", c, e, xc, xe); end
        n_vec++; if (st !== 1'b1) begin n_err++; $display("FAIL bp_stable: got %0b required 1", st); end
        n_vec++; if (io !== 1'b1) begin n_err++; $display("FAIL bp_ready_after_release: got %0b required 1", io); end
        n_vec++; if (ovf_cnt !== m_ovf) begin n_err++; $display("FAIL bp_ovf_cnt: got %0d required %0d", ovf_cnt, m_ovf); end
    endtask

    task automatic test_back_to_back();
        logic [32:0] xc, c, as; logic [1:0] xe, e; logic [35:0] al; int xl, lat, t, t_prev; bit st, io;
        t_prev = -1;
        for (int i = 0; i < 4; i++) begin
            model_cmd(4'b0100, 16'(i + 1), 16'd0, 1'b1, xc, xe, xl);
            issue(4'b0100, 16'(i + 1), 16'd0, 1'b1, 0, lat, c, e, as, al, st, io, t);
            n_vec++; if (c !== xc) begin n_err++; $display("FAIL b2b_c[%0d]: got %0d required %0d", i, c, xc); end
            if (t_prev >= 0) begin
                n_vec++; if (t - t_prev != SETTLE + 2) begin n_err++; $display("FAIL b2b_period[%0d]: got %0d required %0d", i, t - t_prev, SETTLE + 2); end
            end
            t_prev = t;
        end
    endtask

    task automatic test_illegal_op();
        logic [32:0] xc, c, as; logic [1:0] xe, e; logic [35:0] al; int xl, lat, t; bit st, io;
        model_cmd(4'b0011, 16'h00F0, 16'h0F0F, 1'b0, xc, xe, xl);
        issue(4'b0011, 16'h00F0, 16'h0F0F, 1'b0, 0, lat, c, e, as, al, st, io, t);
        n_vec++; if (lat != xl) begin n_err++; $display("FAIL illegal_latency: got %0d required %0d", lat, xl); end
        n_vec++; if (c !== xc || e !== xe) begin n_err++; $display("FAIL illegal_rsp: got %0h/%0b required %0h/%0b", c, e, xc, xe); end
        n_vec++; if (al[35:32] !== m_op) begin n_err++; $display("FAIL illegal_alu_op: got %0h required %0h", al[35:32], m_op); end
        n_vec++; if (as !== m_acc || ovf_cnt !== m_ovf || dz_cnt !== m_dz) begin
            n_err++; $display("FAIL illegal_state: got acc=%0h ovf=%0d dz=%0d required %0h/%0d/%0d", as, ovf_cnt, dz_cnt, m_acc, m_ovf, m_dz);
        end
    endtask

    task automatic test_random();
        logic [32:0] xc, c, as; logic [1:0] xe, e; logic [35:0] al; int xl, lat, t, hold; bit st, io;
        logic [3:0] op; logic [15:0] a, b; logic ua;
        for (int i = 0; i < 150; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(4, 8));
            a  = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            b  = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            ua = 1'($urandom);
            hold = $urandom_range(0, 2);
            model_cmd(op, a, b, ua, xc, xe, xl);
            issue(op, a, b, ua, hold, lat, c, e, as, al, st, io, t);
            n_vec++;
            if (lat != xl || c !== xc || e !== xe || as !== m_acc || al !== {m_op, m_a, m_b} ||
                ovf_cnt !== m_ovf || dz_cnt !== m_dz || st !== 1'b1 || io !== 1'b1) begin
                n_err++;
                $display("FAIL rand[%0d] op=%0h: got lat=%0d c=%0h e=%0b acc=%0h alu=%0h ovf=%0d dz=%0d st=%0b io=%0b required lat=%0d c=%0h e=%0b acc=%0h alu=%0h ovf=%0d dz=%0d",
                         i, op, lat, c, e, as, al, ovf_cnt, dz_cnt, st, io, xl, xc, xe, m_acc, {m_op, m_a, m_b}, m_ovf, m_dz);
            end
        end
    endtask

    task automatic test_saturation();
        logic [32:0] xc, c, as; logic [1:0] xe, e; logic [35:0] al; int xl, lat, t, extra; bit st, io;
        extra = 0;
        for (int i = 0; i < 700 && extra < 6; i++) begin
            if (i % 2 == 0) begin
                model_cmd(4'b0100, 16'hFFFF, 16'hFFFF, 1'b0, xc, xe, xl);
                issue(4'b0100, 16'hFFFF, 16'hFFFF, 1'b0, 0, lat, c, e, as, al, st, io, t);
            end else begin
                model_cmd(4'b0111, 16'd0, 16'd9, 1'b0, xc, xe, xl);
                issue(4'b0111, 16'd0, 16'd9, 1'b0, 0, lat, c, e, as, al, st, io, t);
            end
            if (m_ovf == CMAX && m_dz == CMAX) extra++;
            n_vec++;
            if (ovf_cnt !== m_ovf || dz_cnt !== m_dz) begin
                n_err++; $display("FAIL sat[%0d]: got ovf=%0d dz=%0d required %0d/%0d", i, ovf_cnt, dz_cnt, m_ovf, m_dz);
            end
        end
        n_vec++; if (ovf_cnt !== CMAX || dz_cnt !== CMAX) begin n_err++; $display("FAIL sat_final: got %0d/%0d required %0d", ovf_cnt, dz_cnt, CMAX); end
    endtask

    task automatic test_reset_midflight();
        logic [32:0] xc, c, as; logic [1:0] xe, e; logic [35:0] al; int xl, lat, t; bit st, io, seen;
        while (!cmd_ready) begin @(posedge clk); #1; end
        cmd_valid = 1'b1; cmd_op = 4'b0110; cmd_a = 16'd300; cmd_b = 16'd300; cmd_use_acc = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if ({alu_opcode, alu_a, alu_b, rsp_valid, rsp_c, rsp_error, acc, ovf_cnt, dz_cnt, cmd_ready} !== '0) begin
            n_err++; $display("FAIL midreset_outputs: got rsp_valid=%0b acc=%0h alu_a=%0h ovf=%0d required all zero", rsp_valid, acc, alu_a, ovf_cnt);
        end
        rst = 1'b1;
        seen = 1'b0;
        repeat (5) begin @(posedge clk); #1; if (rsp_valid) seen = 1'b1; end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL midreset_no_rsp: got rsp_valid seen=%0b required 0", seen); end
        model_reset();
        model_cmd(4'b0100, 16'd5, 16'd0, 1'b1, xc, xe, xl);
        issue(4'b0100, 16'd5, 16'd0, 1'b1, 1, lat, c, e, as, al, st, io, t);
        n_vec++; if (lat != 2 || c !== 33'd5 || e !== 2'b00 || as !== 33'd5) begin
            n_err++; $display("FAIL midreset_next_cmd: got lat=%0d c=%0d e=%0b acc=%0d required 2/5/00/5", lat, c, e, as);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_chain();
        test_div_mod();
        test_backpressure();
        test_back_to_back();
        test_illegal_op();
        test_random();
        test_saturation();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
